roce_write_segmenter: RTL and testbench

- Sits directly upstream of the QP state stage on the TX path.
- Accepts one RDMA WRITE work request and segments it into PMTU-sized packets.
- Emits one BTH per packet, plus RETH on the first packet, on the same TX BTH/RETH signals the QP state stage consumes.
- Honours the stop_transfer abort from the QP state stage and reports completion with the next PSN.

---
 rtl/roce_write_segmenter_if.sv | 48 ++++
 rtl/roce_write_segmenter.sv | 171 +++++++++++++++++
 tb/tb_roce_write_segmenter.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/roce_write_segmenter_if.sv
// rtl/roce_write_segmenter_if.sv - WR request, abort, TX BTH/RETH and completion bundle
interface roce_write_segmenter_if;
  logic        s_wr_valid;
  logic        s_wr_ready;
  logic [31:0] s_wr_length;
  logic [63:0] s_wr_rem_addr;
  logic [31:0] s_wr_r_key;
  logic [23:0] s_wr_dest_qp;
  logic [23:0] s_wr_start_psn;
  logic        stop_transfer;
  logic        m_roce_tx_bth_valid;
  logic        m_roce_tx_bth_ready;
  logic [7:0]  m_roce_tx_bth_op_code;
  logic [15:0] m_roce_tx_bth_p_key;
  logic [23:0] m_roce_tx_bth_psn;
  logic [23:0] m_roce_tx_bth_dest_qp;
  logic        m_roce_tx_bth_ack_req;
  logic        m_roce_tx_reth_valid;
  logic [63:0] m_roce_tx_reth_v_addr;
  logic [31:0] m_roce_tx_reth_r_key;
  logic [31:0] m_roce_tx_reth_length;
  logic [15:0] m_payload_length;
  logic        m_done_valid;
  logic        m_done_aborted;
  logic [23:0] m_done_next_psn;

  // Segmenter side: consumes work requests, drives the header stream
  modport master (
    input  s_wr_valid, s_wr_length, s_wr_rem_addr, s_wr_r_key, s_wr_dest_qp,
           s_wr_start_psn, stop_transfer, m_roce_tx_bth_ready,
    output s_wr_ready, m_roce_tx_bth_valid, m_roce_tx_bth_op_code, m_roce_tx_bth_p_key,
           m_roce_tx_bth_psn, m_roce_tx_bth_dest_qp, m_roce_tx_bth_ack_req,
           m_roce_tx_reth_valid, m_roce_tx_reth_v_addr, m_roce_tx_reth_r_key,
           m_roce_tx_reth_length, m_payload_length, m_done_valid, m_done_aborted,
           m_done_next_psn
  );

  // Environment side: issues work requests, accepts headers
  modport slave (
    output s_wr_valid, s_wr_length, s_wr_rem_addr, s_wr_r_key, s_wr_dest_qp,
           s_wr_start_psn, stop_transfer, m_roce_tx_bth_ready,
    input  s_wr_ready, m_roce_tx_bth_valid, m_roce_tx_bth_op_code, m_roce_tx_bth_p_key,
           m_roce_tx_bth_psn, m_roce_tx_bth_dest_qp, m_roce_tx_bth_ack_req,
           m_roce_tx_reth_valid, m_roce_tx_reth_v_addr, m_roce_tx_reth_r_key,
           m_roce_tx_reth_length, m_payload_length, m_done_valid, m_done_aborted,
           m_done_next_psn
  );
endinterface

// File: rtl/roce_write_segmenter.sv
// rtl/roce_write_segmenter.sv - splits one RDMA WRITE request into PMTU-sized BTH/RETH headers
module roce_write_segmenter #(
  parameter int          PMTU_LOG2    = 12,
  parameter int          ACK_INTERVAL = 16,
  parameter logic [15:0] P_KEY        = 16'hFFFF
) (
  input logic                    clk,
  input logic                    rst_n,
  roce_write_segmenter_if.master bus
);
  localparam logic [31:0] PMTU     = 32'd1 << PMTU_LOG2;
  localparam logic [15:0] PMTU16   = PMTU[15:0];
  localparam logic [23:0] ACK_MASK = 24'(ACK_INTERVAL - 1);

  typedef enum logic [2:0] {S_IDLE, S_ONLY, S_FIRST, S_MIDDLE, S_LAST, S_DONE} state_t;

  state_t      r_state;
  logic        r_wr_ready;
  logic        r_bth_valid;
  logic [7:0]  r_op_code;
  logic [15:0] r_p_key;
  logic [23:0] r_psn;
  logic [23:0] r_dest_qp;
  logic        r_ack_req;
  logic        r_reth_valid;
  logic [63:0] r_v_addr;
  logic [31:0] r_r_key;
  logic [31:0] r_length;
  logic [15:0] r_payload;
  logic        r_done_valid;
  logic        r_done_aborted;
  logic [23:0] r_done_next_psn;
  logic [31:0] r_rem;
  logic [23:0] r_idx;
  logic        r_abort_pending;

  logic        w_hs;
  logic [23:0] w_psn_inc;
  logic [31:0] w_rem_next;
  logic [23:0] w_idx_next;
  logic        w_ack_tick;
  logic        w_stop_seg;

  assign w_hs       = r_bth_valid & bus.m_roce_tx_bth_ready;
  assign w_psn_inc  = r_psn + 24'd1;
  assign w_rem_next = r_rem - {16'd0, r_payload};
  assign w_idx_next = r_idx + 24'd1;
  assign w_ack_tick = (w_idx_next & ACK_MASK) == ACK_MASK;
  // ONLY is not abortable: its single header already carries the whole request
  assign w_stop_seg = bus.stop_transfer &
                      ((r_state == S_FIRST) || (r_state == S_MIDDLE) || (r_state == S_LAST));

  assign bus.s_wr_ready            = r_wr_ready;
  assign bus.m_roce_tx_bth_valid   = r_bth_valid;
  assign bus.m_roce_tx_bth_op_code = r_op_code;
  assign bus.m_roce_tx_bth_p_key   = r_p_key;
  assign bus.m_roce_tx_bth_psn     = r_psn;
  assign bus.m_roce_tx_bth_dest_qp = r_dest_qp;
  assign bus.m_roce_tx_bth_ack_req = r_ack_req;
  assign bus.m_roce_tx_reth_valid  = r_reth_valid;
  assign bus.m_roce_tx_reth_v_addr = r_v_addr;
  assign bus.m_roce_tx_reth_r_key  = r_r_key;
  assign bus.m_roce_tx_reth_length = r_length;
  assign bus.m_payload_length      = r_payload;
  assign bus.m_done_valid          = r_done_valid;
  assign bus.m_done_aborted        = r_done_aborted;
  assign bus.m_done_next_psn       = r_done_next_psn;

  // Segmentation FSM; header fields only change on a handshake so stalls hold them stable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_wr_ready      <= 1'b0;
      r_bth_valid     <= 1'b0;
      r_op_code       <= 8'd0;
      r_p_key         <= 16'd0;
      r_psn           <= 24'd0;
      r_dest_qp       <= 24'd0;
      r_ack_req       <= 1'b0;
      r_reth_valid    <= 1'b0;
      r_v_addr        <= 64'd0;
      r_r_key         <= 32'd0;
      r_length        <= 32'd0;
      r_payload       <= 16'd0;
      r_done_valid    <= 1'b0;
      r_done_aborted  <= 1'b0;
      r_done_next_psn <= 24'd0;
      r_rem           <= 32'd0;
      r_idx           <= 24'd0;
      r_abort_pending <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_wr_ready   <= 1'b1;
          r_done_valid <= 1'b0;
          if (bus.s_wr_valid && r_wr_ready) begin
            r_wr_ready      <= 1'b0;
            r_bth_valid     <= 1'b1;
            r_reth_valid    <= 1'b1;
            r_p_key         <= P_KEY;
            r_psn           <= bus.s_wr_start_psn;
            r_dest_qp       <= bus.s_wr_dest_qp;
            r_v_addr        <= bus.s_wr_rem_addr;
            r_r_key         <= bus.s_wr_r_key;
            r_length        <= bus.s_wr_length;
            r_rem           <= bus.s_wr_length;
            r_idx           <= 24'd0;
            r_abort_pending <= 1'b0;
            if (bus.s_wr_length <= PMTU) begin
              r_state   <= S_ONLY;
              r_op_code <= 8'h0A;
              r_payload <= bus.s_wr_length[15:0];
              r_ack_req <= 1'b1;
            end else begin
              r_state   <= S_FIRST;
              r_op_code <= 8'h06;
              r_payload <= PMTU16;
              r_ack_req <= 1'b0;
            end
          end
        end
        S_ONLY, S_LAST: begin
          if (w_hs) begin
            r_state         <= S_DONE;
            r_bth_valid     <= 1'b0;
            r_reth_valid    <= 1'b0;
            r_done_valid    <= 1'b1;
            r_done_aborted  <= r_abort_pending;
            r_done_next_psn <= w_psn_inc;
          end else if (w_stop_seg) begin
            r_abort_pending <= 1'b1;
          end
        end
        S_FIRST, S_MIDDLE: begin
          if (w_hs) begin
            r_psn        <= w_psn_inc;
            r_rem        <= w_rem_next;
            r_idx        <= w_idx_next;
            r_reth_valid <= 1'b0;
            if (r_abort_pending || bus.stop_transfer) begin
              r_state         <= S_DONE;
              r_bth_valid     <= 1'b0;
              r_done_valid    <= 1'b1;
              r_done_aborted  <= 1'b1;
              r_done_next_psn <= w_psn_inc;
            end else if (w_rem_next > PMTU) begin
              r_state   <= S_MIDDLE;
              r_op_code <= 8'h07;
              r_payload <= PMTU16;
              r_ack_req <= w_ack_tick;
            end else begin
              r_state   <= S_LAST;
              r_op_code <= 8'h08;
              r_payload <= w_rem_next[15:0];
              r_ack_req <= 1'b1;
            end
          end else if (w_stop_seg) begin
            r_abort_pending <= 1'b1;
          end
        end
        S_DONE: begin
          r_state         <= S_IDLE;
          r_done_valid    <= 1'b0;
          r_wr_ready      <= 1'b1;
          r_abort_pending <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_roce_write_segmenter.sv
// tb/tb_roce_write_segmenter.sv - scoreboard bench for roce_write_segmenter
module tb_roce_write_segmenter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  roce_write_segmenter_if bus ();

  roce_write_segmenter #(.PMTU_LOG2(12), .ACK_INTERVAL(16), .P_KEY(16'hFFFF)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  localparam logic [63:0] VADDR = 64'h0000_1234_5678_9ABC;
  localparam logic [31:0] RKEY  = 32'hCAFE_F00D;
  localparam logic [23:0] QPN   = 24'h00ABCD;

  typedef struct packed {
    logic [7:0]  op;
    logic [23:0] psn;
    logic [15:0] pay;
    logic        ack;
    logic        reth;
    logic [31:0] rlen;
    logic [63:0] vaddr;
    logic [31:0] rkey;
    logic [23:0] qp;
    logic [15:0] pkey;
  } hdr_t;

  hdr_t        exp_q[$];
  hdr_t        obs_q[$];
  int          total = 0;
  int          passed = 0;
  int          stab_err;
  logic        got_done;
  logic        done_abort;
  logic [23:0] done_psn;
  logic [23:0] exp_next_psn;

  function automatic hdr_t snap();
    hdr_t h;
    h.op    = bus.m_roce_tx_bth_op_code;
    h.psn   = bus.m_roce_tx_bth_psn;
    h.pay   = bus.m_payload_length;
    h.ack   = bus.m_roce_tx_bth_ack_req;
    h.reth  = bus.m_roce_tx_reth_valid;
    h.rlen  = h.reth ? bus.m_roce_tx_reth_length : 32'd0;
    h.vaddr = h.reth ? bus.m_roce_tx_reth_v_addr : 64'd0;
    h.rkey  = h.reth ? bus.m_roce_tx_reth_r_key : 32'd0;
    h.qp    = bus.m_roce_tx_bth_dest_qp;
    h.pkey  = bus.m_roce_tx_bth_p_key;
    return h;
  endfunction

  // Reference segmentation: 4096-byte PMTU, ack every 16th packet; keeps at most max_pkts headers
  task automatic model(input logic [31:0] len, input logic [23:0] spsn, input int max_pkts);
    int n = (len == 0) ? 1 : int'((len + 32'd4095) / 32'd4096);
    int k = (max_pkts >= 0 && max_pkts < n) ? max_pkts : n;
    exp_q.delete();
    for (int i = 0; i < k; i++) begin
      hdr_t h = '0;
      h.psn  = spsn + 24'(i);
      h.qp   = QPN;
      h.pkey = 16'hFFFF;
      if (n == 1) begin
        h.op = 8'h0A; h.pay = len[15:0]; h.ack = 1'b1; h.reth = 1'b1;
      end else if (i == 0) begin
        h.op = 8'h06; h.pay = 16'd4096; h.reth = 1'b1;
      end else if (i == n - 1) begin
        h.op = 8'h08; h.pay = 16'(len - 32'(n - 1) * 32'd4096); h.ack = 1'b1;
      end else begin
        h.op = 8'h07; h.pay = 16'd4096;
      end
      if (i % 16 == 15) h.ack = 1'b1;
      if (h.reth) begin
        h.rlen = len; h.vaddr = VADDR; h.rkey = RKEY;
      end
      exp_q.push_back(h);
    end
    exp_next_psn = spsn + 24'(k);
  endtask

  task automatic issue(input logic [31:0] len, input logic [23:0] spsn);
    for (int k = 0; k < 20 && bus.s_wr_ready !== 1'b1; k++) @(negedge clk);
    total++;
    if (bus.s_wr_ready !== 1'b1) $display("FAIL wr_ready_timeout got %b want 1", bus.s_wr_ready);
    else passed++;
    bus.s_wr_valid = 1'b1;
    bus.s_wr_length = len;
    bus.s_wr_rem_addr = VADDR;
    bus.s_wr_r_key = RKEY;
    bus.s_wr_dest_qp = QPN;
    bus.s_wr_start_psn = spsn;
    @(negedge clk);
    bus.s_wr_valid = 1'b0;
  endtask

  // mode 1 = random ready; ev_kind 1 = stall packet ev_pkt and pulse stop, 2 = stop during its handshake
  task automatic collect(input int mode, input int ev_pkt, input int ev_kind, input int budget);
    hdr_t held = '0;
    logic stalled = 1'b0;
    int   stall_n = 0;
    logic r;
    obs_q.delete();
    got_done = 1'b0;
    stab_err = 0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      bus.stop_transfer = 1'b0;
      if (bus.m_done_valid === 1'b1) begin
        got_done = 1'b1; done_abort = bus.m_done_aborted; done_psn = bus.m_done_next_psn;
        break;
      end
      r = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.m_roce_tx_bth_valid === 1'b1) begin
        if (stalled && snap() !== held) stab_err++;
        if (obs_q.size() == ev_pkt && ev_kind == 1 && stall_n < 3) begin
          r = 1'b0;
          if (stall_n == 0) bus.stop_transfer = 1'b1;
          stall_n++;
        end
        if (obs_q.size() == ev_pkt && ev_kind == 2) begin
          r = 1'b1; bus.stop_transfer = 1'b1;
        end
        if (r) obs_q.push_back(snap());
        stalled = !r;
        held = snap();
      end else begin
        stalled = 1'b0;
      end
      bus.m_roce_tx_bth_ready = r;
      @(negedge clk);
    end
    bus.stop_transfer = 1'b0;
    bus.m_roce_tx_bth_ready = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({bus.s_wr_ready, bus.m_roce_tx_bth_valid, bus.m_roce_tx_reth_valid, bus.m_done_valid,
         bus.m_roce_tx_bth_psn, bus.m_roce_tx_bth_op_code, bus.m_payload_length} !== '0)
      $display("FAIL reset_outputs got rdy=%b v=%b psn=%h op=%h want all 0",
               bus.s_wr_ready, bus.m_roce_tx_bth_valid, bus.m_roce_tx_bth_psn, bus.m_roce_tx_bth_op_code);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.s_wr_ready !== 1'b1) $display("FAIL reset_release_ready got %b want 1", bus.s_wr_ready);
    else passed++;
  endtask

  task automatic test_only();
    model(32'd100, 24'h10, -1);
    issue(32'd100, 24'h10);
    total++;
    if (bus.m_roce_tx_bth_valid !== 1'b1) $display("FAIL only_latency got %b want 1", bus.m_roce_tx_bth_valid);
    else passed++;
    collect(0, -1, 0, 50);
    total++;
    if (obs_q.size() != exp_q.size()) $display("FAIL only_count got %0d want %0d", obs_q.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL only_pkt%0d got %h want %h", i, obs_q[i], exp_q[i]);
      else passed++;
    end
    total++;
    if ({got_done, done_abort, done_psn} !== {1'b1, 1'b0, exp_next_psn})
      $display("FAIL only_done got %b/%b/%h want 1/0/%h", got_done, done_abort, done_psn, exp_next_psn);
    else passed++;
    @(negedge clk);
    total++;
    if ({bus.s_wr_ready, bus.m_done_valid} !== 2'b10)
      $display("FAIL only_after_done got rdy=%b done=%b want 1/0", bus.s_wr_ready, bus.m_done_valid);
    else passed++;
  endtask

  task automatic test_wrap_stop_on_last();
    model(32'd10000, 24'hFFFFFE, -1);
    issue(32'd10000, 24'hFFFFFE);
    collect(0, 2, 2, 50);
    total++;
    if (obs_q.size() != exp_q.size()) $display("FAIL wrap_count got %0d want %0d", obs_q.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL wrap_pkt%0d got %h want %h", i, obs_q[i], exp_q[i]);
      else passed++;
    end
    total++;
    if ({got_done, done_abort, done_psn} !== {1'b1, 1'b0, 24'h000001})
      $display("FAIL wrap_done got %b/%b/%h want 1/0/000001", got_done, done_abort, done_psn);
    else passed++;
  endtask

  task automatic test_zero_len();
    bus.stop_transfer = 1'b1;
    @(negedge clk);
    bus.stop_transfer = 1'b0;
    model(32'd0, 24'h20, -1);
    issue(32'd0, 24'h20);
    collect(0, -1, 0, 50);
    total++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0])
      $display("FAIL zero_pkt got n=%0d %h want n=1 %h", obs_q.size(), obs_q.size() ? obs_q[0] : '0, exp_q[0]);
    else passed++;
    total++;
    if ({got_done, done_abort, done_psn} !== {1'b1, 1'b0, 24'h21})
      $display("FAIL zero_done got %b/%b/%h want 1/0/000021", got_done, done_abort, done_psn);
    else passed++;
  endtask

  task automatic test_ack_interval();
    logic [39:0] acks = '0;
    model(32'd40 * 32'd4096, 24'h0, -1);
    issue(32'd40 * 32'd4096, 24'h0);
    collect(0, -1, 0, 200);
    for (int i = 0; i < 40 && i < obs_q.size(); i++) acks[i] = obs_q[i].ack;
    total++;
    if (acks !== 40'h80_8000_8000) $display("FAIL ack_positions got %h want 8080008000", acks);
    else passed++;
    total++;
    if (obs_q.size() != 40) $display("FAIL ack_count got %0d want 40", obs_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL ack_pkt%0d got %h want %h", i, obs_q[i], exp_q[i]);
      else passed++;
    end
    total++;
    if ({got_done, done_psn} !== {1'b1, 24'd40}) $display("FAIL ack_done got %b/%h want 1/000028", got_done, done_psn);
    else passed++;
  endtask

  task automatic test_backpressure();
    model(32'd10000, 24'hFFFFFE, -1);
    issue(32'd10000, 24'hFFFFFE);
    collect(1, -1, 0, 500);
    total++;
    if (obs_q.size() != exp_q.size()) $display("FAIL bp_count got %0d want %0d", obs_q.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL bp_pkt%0d got %h want %h", i, obs_q[i], exp_q[i]);
      else passed++;
    end
    total++;
    if (stab_err != 0) $display("FAIL bp_stable got %0d changes want 0", stab_err);
    else passed++;
    total++;
    if ({got_done, done_abort, done_psn} !== {1'b1, 1'b0, exp_next_psn})
      $display("FAIL bp_done got %b/%b/%h want 1/0/%h", got_done, done_abort, done_psn, exp_next_psn);
    else passed++;
  endtask

  task automatic test_abort();
    model(32'd5 * 32'd4096, 24'h100, 3);
    issue(32'd5 * 32'd4096, 24'h100);
    collect(0, 2, 1, 100);
    total++;
    if (obs_q.size() != 3) $display("FAIL abort_count got %0d want 3", obs_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL abort_pkt%0d got %h want %h", i, obs_q[i], exp_q[i]);
      else passed++;
    end
    total++;
    if (stab_err != 0) $display("FAIL abort_stable got %0d changes want 0", stab_err);
    else passed++;
    total++;
    if ({got_done, done_abort, done_psn} !== {1'b1, 1'b1, 24'h103})
      $display("FAIL abort_done got %b/%b/%h want 1/1/000103", got_done, done_abort, done_psn);
    else passed++;
  endtask

  task automatic test_mid_reset();
    logic saw_done = 1'b0;
    issue(32'd10000, 24'h50);
    bus.m_roce_tx_bth_ready = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.m_roce_tx_bth_valid, bus.s_wr_ready} !== 2'b00)
      $display("FAIL midreset_async got v=%b rdy=%b want 0/0", bus.m_roce_tx_bth_valid, bus.s_wr_ready);
    else passed++;
    repeat (3) begin
      @(negedge clk);
      if (bus.m_done_valid !== 1'b0) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    @(negedge clk);
    if (bus.m_done_valid !== 1'b0) saw_done = 1'b1;
    total++;
    if ({saw_done, bus.s_wr_ready, bus.m_roce_tx_bth_valid} !== 3'b010)
      $display("FAIL midreset_after got done=%b rdy=%b v=%b want 0/1/0", saw_done, bus.s_wr_ready, bus.m_roce_tx_bth_valid);
    else passed++;
  endtask

  task automatic test_back_to_back();
    for (int w = 0; w < 2; w++) begin
      logic [31:0] len = (w == 0) ? 32'd4097 : 32'd300;
      logic [23:0] sp  = (w == 0) ? 24'h7FFFFF : 24'h800001;
      model(len, sp, -1);
      issue(len, sp);
      collect(0, -1, 0, 50);
      total++;
      if (obs_q.size() != exp_q.size()) $display("FAIL b2b%0d_count got %0d want %0d", w, obs_q.size(), exp_q.size());
      else passed++;
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        total++;
        if (obs_q[i] !== exp_q[i]) $display("FAIL b2b%0d_pkt%0d got %h want %h", w, i, obs_q[i], exp_q[i]);
        else passed++;
      end
      total++;
      if ({got_done, done_abort, done_psn} !== {1'b1, 1'b0, exp_next_psn})
        $display("FAIL b2b%0d_done got %b/%b/%h want 1/0/%h", w, got_done, done_abort, done_psn, exp_next_psn);
      else passed++;
    end
  endtask

  initial begin
    bus.s_wr_valid = 1'b0;
    bus.s_wr_length = '0;
    bus.s_wr_rem_addr = '0;
    bus.s_wr_r_key = '0;
    bus.s_wr_dest_qp = '0;
    bus.s_wr_start_psn = '0;
    bus.stop_transfer = 1'b0;
    bus.m_roce_tx_bth_ready = 1'b1;
    test_reset();
    test_only();
    test_wrap_stop_on_last();
    test_zero_len();
    test_ack_interval();
    test_backpressure();
    test_abort();
    test_mid_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
